state_flag_sequencer: RTL

Sequences the 2-bit state code through 00, 01, 10, 11 for the state-to-flag decode path. Each state is held for a programmable dwell time, and the block produces the registered 2-bit flag for every state. It runs one pass per start request, with busy/done status and an abort. It sits between the control logic that issues start/abort and the downstream consumers of curr_state and flag.

---
 rtl/state_flag_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/state_flag_sequencer.sv
// state_flag_sequencer: steps curr_state 00->01->10->11 with a dwell per state.
// Optional macro STATE_FLAG_HOLD_EN: in state 10, flag keeps its previous value.
module state_flag_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         curr_state,
    output logic [1:0]         flag,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_00 = 2'b00,
        ST_01 = 2'b01,
        ST_10 = 2'b10,
        ST_11 = 2'b11
    } state_t;

    state_t             state_q;
    state_t             nxt_state;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] dwell_q;

    function automatic logic [1:0] flag_code(state_t s);
        logic [1:0] f;
        f = 2'b00;
        unique case (s)
            ST_00: f = 2'b10;
            ST_01: f = 2'b10;
            ST_10: f = 2'b01;
            ST_11: f = 2'b00;
        endcase
        return f;
    endfunction

    assign curr_state = state_q;

    // Next state in the fixed 00->01->10->11 order.
    assign nxt_state = state_t'(state_q + 2'd1);

    // Sequencer: idle/run control, dwell counter and registered flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_00;
            flag    <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start && !abort) begin
                    dwell_q <= dwell;
                    cnt_q   <= dwell;
                    busy    <= 1'b1;
                    state_q <= ST_00;
                    flag    <= flag_code(ST_00);
                end
            end else if (abort) begin
                busy    <= 1'b0;
                state_q <= ST_00;
                flag    <= 2'b00;
                cnt_q   <= '0;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - DWELL_W'(1);
            end else if (state_q == ST_11) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                state_q <= ST_00;
                flag    <= 2'b00;
            end else begin
                state_q <= nxt_state;
                cnt_q   <= dwell_q;
`ifdef STATE_FLAG_HOLD_EN
                if (nxt_state != ST_10) begin
                    flag <= flag_code(nxt_state);
                end
`else
                flag <= flag_code(nxt_state);
`endif
            end
        end
    end

endmodule
